// File: rtl/fp_issue_scheduler_if.sv
// Requester, datapath and response signals of the shared FP issue scheduler.
// The slave modport is the scheduler side; the master modport is the environment side.
interface fp_issue_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req;
  logic [2*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    gnt;
  logic [31:0]           fpu_dataa;
  logic [31:0]           fpu_datab;
  logic                  fpu_add_sub;
  logic [31:0]           fpu_addsub_result;
  logic [31:0]           fpu_mul_result;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;
  logic                  busy;

  modport slave (
    input  req, req_op, req_a, req_b,
    input  fpu_addsub_result, fpu_mul_result,
    output gnt, fpu_dataa, fpu_datab, fpu_add_sub,
    output rsp_valid, rsp_id, rsp_result, busy
  );

  modport master (
    output req, req_op, req_a, req_b,
    output fpu_addsub_result, fpu_mul_result,
    input  gnt, fpu_dataa, fpu_datab, fpu_add_sub,
    input  rsp_valid, rsp_id, rsp_result, busy
  );
endinterface

// File: rtl/fp_issue_scheduler.sv
// Round-robin issue of FP ops onto a shared add/sub + mul datapath,
// with a shifting writeback reservation table so completions never collide.
module fp_issue_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 7,
  parameter int MUL_LAT = 5,
  parameter int ID_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  fp_issue_scheduler_if.slave bus
);

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_NAN  = 2'd3;
  localparam logic [1:0] SRC_ADD = 2'd0;
  localparam logic [1:0] SRC_MUL = 2'd1;
  localparam logic [1:0] SRC_NAN = 2'd2;
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

  logic [ADD_LAT:1] r_vld;
  logic [ID_W-1:0]  r_id  [1:ADD_LAT];
  logic [1:0]       r_src [1:ADD_LAT];
  logic [ID_W-1:0]  r_ptr;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [31:0]      r_rsp_result;

  logic [1:0]         w_op [NUM_REQ];
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_found;
  logic [ID_W-1:0]    w_sel;
  logic [1:0]         w_gop;
  logic [31:0]        w_a;
  logic [31:0]        w_b;
  logic [31:0]        w_cres;

  // An op of latency L needs slot[L+1] free before the shift.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_op[i] = bus.req_op[2*i +: 2];
      unique case (w_op[i])
        OP_MUL:  w_elig[i] = bus.req[i] && !r_vld[MUL_LAT+1];
        OP_NAN:  w_elig[i] = bus.req[i] && !r_vld[2];
        default: w_elig[i] = bus.req[i];
      endcase
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && w_elig[i] &&
            ((int'(r_ptr) + 1 + k) % NUM_REQ) == i) begin
          w_found = 1'b1;
          w_sel   = ID_W'(i);
        end
      end
    end
    if (reset) begin
      w_found = 1'b0;
      w_sel   = '0;
    end
  end

  // w_sel stays 0 without a grant, so requester 0 drives the datapath.
  always_comb begin
    w_gnt = '0;
    w_a   = bus.req_a[31:0];
    w_b   = bus.req_b[31:0];
    w_gop = w_op[0];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == ID_W'(i)) begin
        w_a   = bus.req_a[32*i +: 32];
        w_b   = bus.req_b[32*i +: 32];
        w_gop = w_op[i];
        w_gnt[i] = w_found;
      end
    end
  end

  always_comb begin
    unique case (r_src[1])
      SRC_ADD: w_cres = bus.fpu_addsub_result;
      SRC_MUL: w_cres = bus.fpu_mul_result;
      default: w_cres = 32'h7fffffff;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld        <= '0;
      r_ptr        <= PTR_RST;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      for (int k = 1; k <= ADD_LAT; k++) begin
        r_id[k]  <= '0;
        r_src[k] <= SRC_ADD;
      end
    end else begin
      for (int k = 1; k < ADD_LAT; k++) begin
        r_vld[k] <= r_vld[k+1];
        r_id[k]  <= r_id[k+1];
        r_src[k] <= r_src[k+1];
      end
      r_vld[ADD_LAT] <= 1'b0;
      if (w_found) begin
        r_ptr <= w_sel;
        unique case (w_gop)
          OP_MUL: begin
            r_vld[MUL_LAT] <= 1'b1;
            r_id[MUL_LAT]  <= w_sel;
            r_src[MUL_LAT] <= SRC_MUL;
          end
          OP_NAN: begin
            r_vld[1] <= 1'b1;
            r_id[1]  <= w_sel;
            r_src[1] <= SRC_NAN;
          end
          default: begin
            r_vld[ADD_LAT] <= 1'b1;
            r_id[ADD_LAT]  <= w_sel;
            r_src[ADD_LAT] <= SRC_ADD;
          end
        endcase
      end
      r_rsp_valid <= r_vld[1];
      if (r_vld[1]) begin
        r_rsp_id     <= r_id[1];
        r_rsp_result <= w_cres;
      end
    end
  end

  assign bus.gnt         = w_gnt;
  assign bus.fpu_dataa   = w_a;
  assign bus.fpu_datab   = w_b;
  assign bus.fpu_add_sub = (w_gop == OP_ADD);
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_id      = r_rsp_id;
  assign bus.rsp_result  = r_rsp_result;
  assign bus.busy        = |r_vld;

endmodule

// File: tb/tb_fp_issue_scheduler.sv
// Bench for fp_issue_scheduler: integer stand-in datapath, directed tables,
// hand sequences and random traffic against a booking-calendar model.
module tb_fp_issue_scheduler;
  localparam int N       = 4;
  localparam int ADD_LAT = 7;
  localparam int MUL_LAT = 5;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_issue_scheduler_if #(.NUM_REQ(N), .ID_W(ID_W)) bus ();

  fp_issue_scheduler #(
    .NUM_REQ(N), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .ID_W(ID_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Stand-in datapath: integer add/sub and mul with the real latencies.
  logic [31:0] add_pipe [ADD_LAT];
  logic [31:0] mul_pipe [MUL_LAT];
  always @(posedge clk) begin
    add_pipe[0] <= bus.fpu_add_sub ? bus.fpu_dataa + bus.fpu_datab
                                   : bus.fpu_dataa - bus.fpu_datab;
    mul_pipe[0] <= bus.fpu_dataa * bus.fpu_datab;
    for (int k = 1; k < ADD_LAT; k++) add_pipe[k] <= add_pipe[k-1];
    for (int k = 1; k < MUL_LAT; k++) mul_pipe[k] <= mul_pipe[k-1];
  end
  assign bus.fpu_addsub_result = add_pipe[ADD_LAT-1];
  assign bus.fpu_mul_result    = mul_pipe[MUL_LAT-1];

  logic [N-1:0] req;
  logic [1:0]   op [N];
  logic [31:0]  a  [N];
  logic [31:0]  b  [N];

  // Model: writeback cycles already booked, and expected responses by cycle.
  bit          resv    [int];
  int          exp_id  [int];
  logic [31:0] exp_res [int];
  int          ptr, t;
  logic [31:0] last_id, last_res;
  int          passed, total;

  logic [N-1:0]    s_gnt;
  logic            s_rv;
  logic [ID_W-1:0] s_rid;
  logic [31:0]     s_rres;
  logic            s_busy;

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;
  vec_t vt [5];

  function automatic int lat_of(input logic [1:0] o);
    if (o == 2'd2) return MUL_LAT;
    if (o == 2'd3) return 1;
    return ADD_LAT;
  endfunction

  function automatic logic [31:0] fres(input logic [1:0] o,
                                       input logic [31:0] x,
                                       input logic [31:0] y);
    case (o)
      2'd0:    return x + y;
      2'd1:    return x - y;
      2'd2:    return x * y;
      default: return 32'h7fffffff;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s t=%0d: got %h want %h", nm, t, act, exp);
  endtask

  task automatic model_reset();
    resv.delete();
    exp_id.delete();
    exp_res.delete();
    ptr = N - 1;
    last_id = 0;
    last_res = 0;
    t = 0;
  endtask

  task automatic drive();
    bus.req = req;
    for (int i = 0; i < N; i++) begin
      bus.req_op[2*i +: 2] = op[i];
      bus.req_a[32*i +: 32] = a[i];
      bus.req_b[32*i +: 32] = b[i];
    end
  endtask

  task automatic sample();
    s_gnt  = bus.gnt;
    s_rv   = bus.rsp_valid;
    s_rid  = bus.rsp_id;
    s_rres = bus.rsp_result;
    s_busy = bus.busy;
  endtask

  // One cycle: drive at negedge, check, then cross the active edge.
  task automatic step();
    int g;
    int l;
    logic bexp;
    drive();
    #1;
    sample();
    if (exp_id.exists(t)) begin
      chk("rsp_valid", s_rv, 1);
      chk("rsp_id", s_rid, exp_id[t]);
      chk("rsp_result", s_rres, exp_res[t]);
      last_id = exp_id[t];
      last_res = exp_res[t];
    end else begin
      chk("rsp_valid_idle", s_rv, 0);
      chk("rsp_id_hold", s_rid, last_id);
      chk("rsp_result_hold", s_rres, last_res);
    end
    bexp = 1'b0;
    foreach (resv[k]) if (k >= t) bexp = 1'b1;
    chk("busy", s_busy, bexp);
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (g < 0 && req[i] && !resv.exists(t + lat_of(op[i]))) g = i;
    end
    chk("gnt", s_gnt, (g >= 0) ? (1 << g) : 0);
    if (g >= 0) begin
      l = lat_of(op[g]);
      chk("fpu_dataa", bus.fpu_dataa, a[g]);
      chk("fpu_datab", bus.fpu_datab, b[g]);
      if (op[g] < 2'd2) chk("fpu_add_sub", bus.fpu_add_sub, op[g] == 2'd0);
      resv[t + l] = 1'b1;
      exp_id[t + l + 1] = g;
      exp_res[t + l + 1] = fres(op[g], a[g], b[g]);
      ptr = g;
    end else begin
      chk("fpu_dataa_idle", bus.fpu_dataa, a[0]);
    end
    @(posedge clk);
    @(negedge clk);
    t++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    sample();
    chk("rst_gnt", s_gnt, 0);
    chk("rst_rsp_valid", s_rv, 0);
    chk("rst_rsp_id", s_rid, 0);
    chk("rst_rsp_result", s_rres, 0);
    chk("rst_busy", s_busy, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    req = '0;
    repeat (ADD_LAT + 3) step();
  endtask

  initial begin
    passed = 0;
    total = 0;
    t = 0;
    vt[0] = '{0, 2'd0, 32'h3f800000, 32'h40000000, 32'h7f800000, ADD_LAT};
    vt[1] = '{1, 2'd2, 32'h00001234, 32'h00000010, 32'h00012340, MUL_LAT};
    vt[2] = '{3, 2'd3, 32'h11111111, 32'h22222222, 32'h7fffffff, 1};
    vt[3] = '{2, 2'd1, 32'h00000010, 32'h00000003, 32'h0000000d, ADD_LAT};
    vt[4] = '{1, 2'd0, 32'hffffffff, 32'h00000001, 32'h00000000, ADD_LAT};
    for (int i = 0; i < N; i++) begin
      op[i] = 2'd0;
      a[i] = 32'h0;
      b[i] = 32'h0;
    end
    req = '1;
    reset = 1'b1;
    drive();
    #2;
    sample();
    chk("init_gnt", s_gnt, 0);
    chk("init_rsp_valid", s_rv, 0);
    chk("init_rsp_id", s_rid, 0);
    chk("init_rsp_result", s_rres, 0);
    chk("init_busy", s_busy, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // All four hold adds: strict rotation from requester 0.
    for (int i = 0; i < N; i++) begin
      a[i] = i;
      b[i] = 32'h100;
    end
    req = '1;
    for (int c = 0; c < 16; c++) begin
      step();
      if (c < 6) chk("rr_gnt", s_gnt, 1 << (c % N));
      if (c == 5) req = '0;
      if (c >= 8 && c < 14) begin
        chk("rr_rv", s_rv, 1);
        chk("rr_id", s_rid, (c - 8) % N);
      end
    end
    drain();

    // Isolated ops: grant in cycle 0, response exactly in cycle L+1.
    foreach (vt[v]) begin
      req = '0;
      req[vt[v].id] = 1'b1;
      op[vt[v].id] = vt[v].op;
      a[vt[v].id] = vt[v].a;
      b[vt[v].id] = vt[v].b;
      for (int c = 0; c <= vt[v].lat + 2; c++) begin
        step();
        if (c == 0) begin
          chk("tv_gnt", s_gnt, 1 << vt[v].id);
          req = '0;
        end
        if (c == vt[v].lat + 1) begin
          chk("tv_rv", s_rv, 1);
          chk("tv_id", s_rid, vt[v].id);
          chk("tv_result", s_rres, vt[v].res);
        end else begin
          chk("tv_no_rsp", s_rv, 0);
        end
        if (c >= 1 && c <= vt[v].lat) chk("tv_busy", s_busy, 1);
      end
    end
    drain();

    // Mul asserted two cycles after an add lands on the same writeback slot.
    req = '0;
    req[0] = 1'b1;
    op[0] = 2'd0;
    a[0] = 32'h10;
    b[0] = 32'h20;
    for (int c = 0; c < 11; c++) begin
      step();
      if (c == 0) begin
        chk("col_gnt0", s_gnt, 1);
        req[0] = 1'b0;
      end
      if (c == 1) begin
        req[2] = 1'b1;
        op[2] = 2'd2;
        a[2] = 32'd7;
        b[2] = 32'd6;
      end
      if (c == 2) chk("col_blocked", s_gnt, 0);
      if (c == 3) begin
        chk("col_gnt2", s_gnt, 4);
        req[2] = 1'b0;
      end
      if (c == 8) begin
        chk("col_rv0", s_rv, 1);
        chk("col_id0", s_rid, 0);
        chk("col_res0", s_rres, 32'h30);
      end
      if (c == 9) begin
        chk("col_rv2", s_rv, 1);
        chk("col_id2", s_rid, 2);
        chk("col_res2", s_rres, 32'd42);
      end
    end
    drain();

    // Reset clears a response strobe that is already up.
    req = '0;
    req[3] = 1'b1;
    op[3] = 2'd3;
    step();
    chk("nan_gnt", s_gnt, 8);
    req = '0;
    step();
    chk("pre_rst_rv", bus.rsp_valid, 1);
    chk("pre_rst_id", bus.rsp_id, 3);
    chk("pre_rst_res", bus.rsp_result, 32'h7fffffff);
    do_reset();

    // Three adds in flight, then asynchronous reset in cycle 4.
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b1;
      op[i] = 2'd0;
    end
    for (int c = 0; c < 4; c++) begin
      step();
      if (c < 3) chk("rst_seq_gnt", s_gnt, 1 << c);
      req = req & ~s_gnt;
    end
    req[0] = 1'b1;
    drive();
    #1;
    chk("pre_rst_busy", bus.busy, 1);
    chk("pre_rst_gnt", bus.gnt, 1);
    do_reset();
    req = '1;
    for (int i = 0; i < N; i++) op[i] = 2'd0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (c == 0) chk("post_rst_gnt", s_gnt, 1);
      if (c >= 3 && c <= 5) chk("post_rst_no_rsp", s_rv, 0);
      req = req & ~s_gnt;
    end
    drain();

    // Random traffic with occasional resets.
    for (int n = 0; n < 900; n++) begin
      if (n % 300 == 299) begin
        do_reset();
      end else begin
        for (int i = 0; i < N; i++) begin
          if (req[i] && s_gnt[i]) req[i] = 1'b0;
          if (!req[i] && $urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            op[i] = 2'($urandom_range(0, 3));
            a[i] = $urandom;
            b[i] = $urandom;
          end
        end
        step();
      end
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fp_issue_scheduler.md
Name: fp_issue_scheduler

Overview:
- Shares one pipelined FP datapath (add/sub unit plus mul unit, fixed latencies, clk_en tied high) between NUM_REQ requesters.
- Issues at most one operation per cycle, chosen by round-robin arbitration.
- Reserves the single writeback slot in advance so that add/sub and mul results never complete in the same cycle.
- Returns each result tagged with its requester ID. Sits between the NIOS-side custom-instruction front ends and the shared altfp datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADD_LAT, 7, add/sub datapath latency in cycles
- MUL_LAT, 5, mul datapath latency in cycles (MUL_LAT < ADD_LAT)
- ID_W, 2, requester ID width, equal to clog2(NUM_REQ)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req  in  NUM_REQ  per-requester request, held until granted
- req_op  in  2*NUM_REQ  per-requester opcode: 0 add, 1 sub, 2 mul, 3 invalid
- req_a  in  32*NUM_REQ  per-requester operand A (IEEE754 single)
- req_b  in  32*NUM_REQ  per-requester operand B
- gnt  out  NUM_REQ  one-hot grant; combinational; issue occurs at the following edge
- fpu_dataa  out  32  operand A of the granted request
- fpu_datab  out  32  operand B of the granted request
- fpu_add_sub  out  1  high = add, low = sub
- fpu_addsub_result  in  32  add/sub datapath output
- fpu_mul_result  in  32  mul datapath output
- rsp_valid  out  1  one-cycle result strobe
- rsp_id  out  ID_W  requester of the result
- rsp_result  out  32  result value
- busy  out  1  high while any operation is in flight

Behaviour:
- Reset (async, any time):
  - All reservation slots cleared; in-flight results discarded and never reported.
  - rsp_valid=0, rsp_id=0, rsp_result=0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - gnt forced to 0 while reset is high.
- Latency per op: L = ADD_LAT for opcodes 0/1, MUL_LAT for 2, 1 for 3.
- Reservation table: slots 1..ADD_LAT, each holding {valid, id, src}, where src is addsub, mul or nan.
  - Every edge: slot[k] <= slot[k+1]; slot[ADD_LAT] <= empty.
  - An issue writes its entry into slot[L] (post-shift position).
- Eligibility: requester i is eligible when req[i]=1 and slot[L_i+1] is invalid. slot[ADD_LAT+1] does not exist and always counts as free.
- Arbitration:
  - Round-robin among eligible requesters, searching from pointer+1 upward with wrap.
  - At most one gnt bit per cycle. The pointer updates to the granted index on grant only.
  - Ineligible requesters are skipped without losing their place.
- Datapath drive:
  - fpu_dataa/fpu_datab/fpu_add_sub carry the granted requester's fields in the grant cycle.
  - When there is no grant, they hold the requester-0 fields (don't-care to the datapath).
  - Opcode 3 does not use the datapath.
- Completion: in a cycle where slot[1] is valid, the result is selected by src: fpu_addsub_result, fpu_mul_result, or 32'h7fffffff.
  - At the next edge: rsp_valid <= 1, rsp_id <= slot[1].id, rsp_result <= the selected value.
  - Otherwise rsp_valid <= 0, and rsp_id/rsp_result hold their previous values.
- Timing: a grant in cycle 0 gives rsp_valid in cycle L+1. Responses appear strictly in completion order, never two per cycle.
- No backpressure: consumers must accept rsp in the strobe cycle.
- busy = OR of slot valids.
- Simultaneous request and completion is allowed. The slot freed by the shift is usable in the same cycle, per the eligibility rule.

Test Plan:
- req0 add 3f800000 + 40000000 at cycle 0 → gnt[0] in cycle 0; rsp_valid in cycle 8 with id=0, result 40400000; busy high in cycles 1..7.
- req1 mul 40000000 * 40000000 → rsp in cycle 6 with id=1, result 40800000; fpu_add_sub is don't-care.
- Collision:
  - req0 add granted in cycle 0; req2 mul asserted in cycle 2 → gnt[2] low in cycle 2, high in cycle 3.
  - Responses: id0 in cycle 8, id2 in cycle 9. No cycle ever has two completions.
- All four requesters hold add requests continuously after reset → grants 0,1,2,3,0,1 on consecutive cycles; rsp ids in the same order starting at cycle 8.
- req3 opcode 3 → granted in cycle 0; rsp in cycle 2 with id=3, result 7fffffff.
- Three adds issued in cycles 0..2, reset pulsed in cycle 4 (mid-cycle, asynchronous):
  - Immediately: rsp_valid=0, busy=0, gnt=0.
  - No responses in cycles 8..10.
  - The first request after reset goes to requester 0.
